// File: rtl/nin_gate_sweeper.sv
// N-input reduction gate with an exhaustive sweep engine that captures the truth table.
// Outside a sweep it behaves as a registered gate on ext_in.
module nin_gate_sweeper #(
  parameter int N           = 3,
  parameter int STEP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode,
  input  logic              ext_en,
  input  logic [N-1:0]      ext_in,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      pattern,
  output logic              gate_out,
  output logic [2**N-1:0]   truth_table,
  output logic [N:0]        ones_count
);

  // state   | meaning
  // IDLE    | registered gate on ext_in, waiting for start
  // RUN     | stepping pattern through all 2^N combinations
  // DONE    | one-cycle completion pulse
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int HW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [1:0]    state_q;
  logic [2:0]    mode_q;
  logic [HW-1:0] hold_q;
  logic          f_ext;
  logic          f_pat;
  logic          hold_last;
  logic          pat_last;

  function automatic logic gate_f(input logic [2:0] m, input logic [N-1:0] x);
    logic r;
    case (m)
      3'b000:  r = &x;
      3'b001:  r = ~&x;
      3'b010:  r = |x;
      3'b011:  r = ~|x;
      3'b100:  r = ^x;
      3'b101:  r = ~^x;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    f_ext     = gate_f(mode, ext_in);
    f_pat     = gate_f(mode_q, pattern);
    hold_last = (hold_q == HW'(STEP_CYCLES - 1));
    pat_last  = &pattern;
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 3'b000;
      hold_q      <= '0;
      pattern     <= '0;
      gate_out    <= 1'b0;
      truth_table <= '0;
      ones_count  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ext_en)
            gate_out <= f_ext;
          if (start && !abort) begin
            state_q     <= ST_RUN;
            mode_q      <= mode;
            pattern     <= '0;
            truth_table <= '0;
            ones_count  <= '0;
            hold_q      <= '0;
          end
        end
        ST_RUN: begin
          gate_out <= f_pat;
          if (abort) begin
            // pattern holds on abort; only the final write is allowed to land
            state_q <= ST_IDLE;
            if (hold_last && pat_last) begin
              truth_table[pattern] <= f_pat;
              ones_count           <= ones_count + (N+1)'(f_pat);
            end
          end else if (hold_last) begin
            hold_q               <= '0;
            truth_table[pattern] <= f_pat;
            ones_count           <= ones_count + (N+1)'(f_pat);
            pattern              <= pattern + N'(1);
            if (pat_last)
              state_q <= ST_DONE;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nin_gate_sweeper.sv
// Scoreboard bench for nin_gate_sweeper: three instances (N=3/S=1, N=3/S=3, N=8/S=1).
module tb_nin_gate_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1, start2;
  logic       abort;
  logic [2:0] mode;
  logic       ext_en;
  logic [7:0] ext_in;

  logic         busy_v [3];
  logic         done_v [3];
  logic         gate_v [3];
  logic [7:0]   pat_v  [3];
  logic [255:0] tt_v   [3];
  logic [8:0]   ones_v [3];

  logic       busy0, done0, gate0, busy1, done1, gate1, busy2, done2, gate2;
  logic [2:0] pat0, pat1;
  logic [7:0] pat2;
  logic [7:0] tt0, tt1;
  logic [255:0] tt2;
  logic [3:0] ones0, ones1;
  logic [8:0] ones2;

  nin_gate_sweeper #(.N(3), .STEP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .mode(mode),
    .ext_en(ext_en), .ext_in(ext_in[2:0]), .busy(busy0), .done(done0),
    .pattern(pat0), .gate_out(gate0), .truth_table(tt0), .ones_count(ones0));

  nin_gate_sweeper #(.N(3), .STEP_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .mode(mode),
    .ext_en(ext_en), .ext_in(ext_in[2:0]), .busy(busy1), .done(done1),
    .pattern(pat1), .gate_out(gate1), .truth_table(tt1), .ones_count(ones1));

  nin_gate_sweeper #(.N(8), .STEP_CYCLES(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .mode(mode),
    .ext_en(ext_en), .ext_in(ext_in), .busy(busy2), .done(done2),
    .pattern(pat2), .gate_out(gate2), .truth_table(tt2), .ones_count(ones2));

  always_comb begin
    busy_v[0] = busy0; done_v[0] = done0; gate_v[0] = gate0;
    pat_v[0] = 8'(pat0); tt_v[0] = 256'(tt0); ones_v[0] = 9'(ones0);
    busy_v[1] = busy1; done_v[1] = done1; gate_v[1] = gate1;
    pat_v[1] = 8'(pat1); tt_v[1] = 256'(tt1); ones_v[1] = 9'(ones1);
    busy_v[2] = busy2; done_v[2] = done2; gate_v[2] = gate2;
    pat_v[2] = pat2; tt_v[2] = tt2; ones_v[2] = ones2;
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        tag;
    logic [255:0] tt;
    int           ones;
    int           done_at;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   t0      = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [255:0] tt, input int ones, input int done_at);
    exp_t e;
    e.tag = tag; e.tt = tt; e.ones = ones; e.done_at = done_at;
    sb.push_back(e);
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic start_sweep(input int w, input logic [2:0] m);
    @(negedge clk);
    mode = m;
    set_start(w, 1'b1);
    @(posedge clk);
    #1;
    t0 = cyc;
    set_start(w, 1'b0);
  endtask

  // wait for done, then pop the scoreboard entry and compare the captured results
  task automatic wait_done_check(input int w, input int limit);
    exp_t e;
    bit   seen = 0;
    e = sb.pop_front();
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_v[w]) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      chk({e.tag, "_timeout"}, 256'(0), 256'(1));
    end else begin
      chk({e.tag, "_done_at"}, 256'(cyc - t0 + 1), 256'(e.done_at));
      chk({e.tag, "_busy_at_done"}, 256'(busy_v[w]), 256'(0));
      chk({e.tag, "_tt"}, tt_v[w], e.tt);
      chk({e.tag, "_ones"}, 256'(ones_v[w]), 256'(e.ones));
      @(negedge clk);
      chk({e.tag, "_done_1cyc"}, 256'(done_v[w]), 256'(0));
    end
  endtask

  initial begin
    exp_t e;
    int   pulses;
    bit   hit;
    rst_n = 1'b1; start0 = 0; start1 = 0; start2 = 0; abort = 0;
    mode = 3'b000; ext_en = 0; ext_in = 8'h00;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 256'(busy_v[0]), 256'(0));
    chk("rst_done", 256'(done_v[0]), 256'(0));
    chk("rst_gate", 256'(gate_v[0]), 256'(0));
    chk("rst_pat", 256'(pat_v[0]), 256'(0));
    chk("rst_tt", tt_v[0], 256'(0));
    chk("rst_ones", 256'(ones_v[0]), 256'(0));
    rst_n = 1'b1;

    // IDLE external gating
    @(negedge clk);
    ext_en = 1; ext_in = 8'hFF; mode = 3'b011;
    @(posedge clk); #1;
    chk("ext_nor_111", 256'(gate_v[0]), 256'(0));
    mode = 3'b000;
    @(posedge clk); #1;
    chk("ext_and_111", 256'(gate_v[0]), 256'(1));
    ext_en = 0; mode = 3'b011;
    @(posedge clk); #1;
    chk("ext_hold", 256'(gate_v[0]), 256'(1));

    // AND sweep
    push_exp("and", 256'h80, 1, 9);
    start_sweep(0, 3'b000);
    @(negedge clk);
    chk("and_busy", 256'(busy_v[0]), 256'(1));
    wait_done_check(0, 30);

    // NAND then XNOR back to back
    push_exp("nand", 256'h7F, 7, 9);
    start_sweep(0, 3'b001);
    wait_done_check(0, 30);
    push_exp("xnor", 256'h69, 4, 9);
    start_sweep(0, 3'b101);
    @(negedge clk);
    chk("xnor_tt_cleared", tt_v[0], 256'(0));
    chk("xnor_ones_cleared", 256'(ones_v[0]), 256'(0));
    wait_done_check(0, 30);

    // XOR with 3-cycle steps; mode change mid-run is ignored
    push_exp("xor_s3", 256'h96, 4, 25);
    start_sweep(1, 3'b100);
    mode = 3'b000;
    wait_done_check(1, 60);

    // OR sweep aborted during pattern 4
    push_exp("or_abort", 256'h0E, 3, 0);
    start_sweep(0, 3'b010);
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pat_v[0] == 8'd4) begin
        hit = 1;
        break;
      end
    end
    chk("or_abort_reach_p4", 256'(hit), 256'(1));
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "_busy"}, 256'(busy_v[0]), 256'(0));
    chk({e.tag, "_pat"}, 256'(pat_v[0]), 256'(4));
    chk({e.tag, "_tt"}, tt_v[0], e.tt);
    chk({e.tag, "_ones"}, 256'(ones_v[0]), 256'(e.ones));
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_v[0]) pulses++;
    end
    chk("or_abort_no_done", 256'(pulses), 256'(0));

    // start and abort together in IDLE
    @(negedge clk);
    start0 = 1; abort = 1; mode = 3'b000;
    @(posedge clk); #1;
    start0 = 0; abort = 0;
    @(negedge clk);
    chk("start_abort_busy", 256'(busy_v[0]), 256'(0));
    chk("start_abort_tt", tt_v[0], 256'h0E);

    // async reset mid-sweep
    start_sweep(0, 3'b000);
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pat_v[0] == 8'd5) begin
        hit = 1;
        break;
      end
    end
    chk("rst_mid_reach_p5", 256'(hit), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 256'(busy_v[0]), 256'(0));
    chk("rst_mid_pat", 256'(pat_v[0]), 256'(0));
    chk("rst_mid_tt", tt_v[0], 256'(0));
    chk("rst_mid_ones", 256'(ones_v[0]), 256'(0));
    chk("rst_mid_gate", 256'(gate_v[0]), 256'(0));
    @(negedge clk);
    chk("rst_mid_done", 256'(done_v[0]), 256'(0));
    rst_n = 1'b1;

    // N=8 AND sweep
    push_exp("and_n8", 256'(1) << 255, 1, 257);
    start_sweep(2, 3'b000);
    wait_done_check(2, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
